// File: rtl/prg_loader.sv
// ----------------------------------------------------------------------------
// prg_loader
//
// Streaming program/cartridge loader placed between the data_io download port
// and the external-memory arbiter.
//
//  * Optionally parses a two-byte little-endian load address at the start of
//    a download; otherwise the image loads at FIXED_ADDR.
//  * Payload bytes are buffered in a small FIFO and written to memory one at a
//    time over a req/ack handshake. The registered mem_* outputs act as the
//    FIFO's read register, so up to FIFO_DEPTH+1 bytes can be in flight.
//  * After the payload has drained, the end-of-program address is written
//    (low byte, then high byte) to each entry of a table of zero-page
//    pointer locations.
//  * If the image was loaded at AUTORUN_ADDR, force_reset pulses for
//    RESET_HOLD cycles.
//
// Ports
//  clk_sys      in   system clock
//  reset_n      in   asynchronous active-low reset
//  dl_active    in   download in progress (rising edge starts a download)
//  dl_wr        in   one-cycle byte strobe
//  dl_data      in   download byte
//  hdr_mode     in   1: first two bytes are the load address (sampled at start)
//  inject_en    in   1: inject end pointers after load (sampled at start)
//  mem_req      out  memory write request
//  mem_addr     out  write address
//  mem_dout     out  write data
//  mem_ack      in   write accepted
//  busy         out  loader is not idle
//  end_addr     out  load address + payload byte count
//  overrun      out  sticky: a byte was dropped
//  hdr_err      out  sticky: download ended inside the header
//  wrap         out  sticky: payload address wrapped past all-ones
//  force_reset  out  autostart reset pulse
// ----------------------------------------------------------------------------
module prg_loader #(
    parameter int                 AW           = 16,
    parameter int                 FIFO_DEPTH   = 4,
    parameter int                 NPTR         = 4,
    parameter logic [NPTR*16-1:0] PTR_ADDRS    = {16'h00ae, 16'h0031, 16'h002f, 16'h002d},
    parameter logic [15:0]        FIXED_ADDR   = 16'ha000,
    parameter logic [15:0]        AUTORUN_ADDR = 16'ha000,
    parameter int                 RESET_HOLD   = 32
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [7:0]    dl_data,
    input  logic          hdr_mode,
    input  logic          inject_en,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    input  logic          mem_ack,
    output logic          busy,
    output logic [AW-1:0] end_addr,
    output logic          overrun,
    output logic          hdr_err,
    output logic          wrap,
    output logic          force_reset
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int            PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            IW        = $clog2(2 * NPTR + 1);   // injection step counter
    localparam int            TW        = IW - 1;                 // pointer-table index width
    localparam int            TN        = 1 << TW;                // padded table size
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] INJ_LAST  = IW'(2 * NPTR);
    localparam logic [31:0]   HOLD_LAST = 32'(RESET_HOLD - 1);
    localparam logic [AW-1:0] FIXED_C   = AW'(FIXED_ADDR);
    localparam logic [AW-1:0] AUTORUN_C = AW'(AUTORUN_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        DRAIN,
        INJECT,
        RST
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_reg;
    logic            dl_active_q_reg;
    logic            inject_en_reg;
    logic [7:0]      load_lo_reg;
    logic [AW-1:0]   load_addr_reg;
    logic [AW-1:0]   addr_cnt_reg;     // address of the next byte to be presented
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     fifo_count_reg;
    logic [IW-1:0]   inj_idx_reg;      // number of injection writes presented
    logic [31:0]     hold_cnt_reg;

    logic [7:0]      fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Pointer table, padded to a power of two so the injection counter can
    // index it directly without a range check.
    // ------------------------------------------------------------------------
    logic [AW-1:0]   ptr_tab [TN];

    generate
        for (genvar gi = 0; gi < TN; gi++) begin : g_ptr
            if (gi < NPTR) begin : g_used
                assign ptr_tab[gi] = AW'(PTR_ADDRS[gi*16 +: 16]);
            end else begin : g_pad
                assign ptr_tab[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic            dl_rise;
    logic            fifo_empty;
    logic            fifo_full;
    logic            out_free;     // output register can take a new byte this cycle
    logic            pop;
    logic            push;
    logic            drop;
    logic            inj_present;
    logic            autorun_hit;
    logic [AW-1:0]   inj_addr;
    logic [7:0]      inj_data;

    always_comb begin
        dl_rise     = dl_active && !dl_active_q_reg;
        fifo_empty  = (fifo_count_reg == '0);
        fifo_full   = (fifo_count_reg == DEPTH_C);
        out_free    = !mem_req || mem_ack;

        // The FIFO is always empty during injection; excluding INJECT keeps
        // the output register dedicated to pointer writes there.
        pop         = (state_reg != INJECT) && !fifo_empty && out_free;

        // A push into a full FIFO is fine if the head leaves in the same cycle.
        push        = (state_reg == DATA) && dl_wr && (!fifo_full || pop);

        inj_present = (state_reg == INJECT) && (inj_idx_reg != INJ_LAST) && out_free;
        inj_addr    = ptr_tab[inj_idx_reg[IW-1:1]] + AW'(inj_idx_reg[0]);
        inj_data    = inj_idx_reg[0] ? end_addr[15:8] : end_addr[7:0];

        autorun_hit = (load_addr_reg == AUTORUN_C);

        // Bytes are only consumed in the header and data states. A strobe in
        // the same cycle as the download start is not part of the image.
        case (state_reg)
            IDLE:           drop = dl_wr && !dl_rise;
            HDR_LO, HDR_HI: drop = 1'b0;
            DATA:           drop = dl_wr && !push;
            default:        drop = dl_wr;
        endcase
    end

    // ------------------------------------------------------------------------
    // Payload buffer storage (no reset; contents are qualified by the count)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= dl_data;
        end
    end

    // ------------------------------------------------------------------------
    // FSM, FIFO pointers and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            dl_active_q_reg <= 1'b0;
            inject_en_reg   <= 1'b0;
            load_lo_reg     <= '0;
            load_addr_reg   <= '0;
            addr_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fifo_count_reg  <= '0;
            inj_idx_reg     <= '0;
            hold_cnt_reg    <= '0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_dout        <= '0;
            busy            <= 1'b0;
            end_addr        <= '0;
            overrun         <= 1'b0;
            hdr_err         <= 1'b0;
            wrap            <= 1'b0;
            force_reset     <= 1'b0;
        end else begin
            dl_active_q_reg <= dl_active;

            // ---------------- FIFO bookkeeping ----------------
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: ;
            endcase

            if (drop) begin
                overrun <= 1'b1;
            end

            // ---------------- write completion ----------------
            // end_addr tracks payload writes only, so it stays frozen while
            // the pointer table is being written.
            if (mem_req && mem_ack && (state_reg != INJECT)) begin
                end_addr <= mem_addr + 1'b1;
                if (mem_addr == '1) begin
                    wrap <= 1'b1;
                end
            end

            // ---------------- output register ----------------
            if (pop) begin
                mem_req      <= 1'b1;
                mem_addr     <= addr_cnt_reg;
                mem_dout     <= fifo_mem[rd_ptr_reg];
                addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end else if (inj_present) begin
                mem_req      <= 1'b1;
                mem_addr     <= inj_addr;
                mem_dout     <= inj_data;
                inj_idx_reg  <= inj_idx_reg + 1'b1;
            end else if (mem_ack) begin
                mem_req      <= 1'b0;
            end

            // ---------------- sequencing ----------------
            case (state_reg)
                IDLE: begin
                    if (dl_rise) begin
                        inject_en_reg  <= inject_en;
                        overrun        <= 1'b0;
                        hdr_err        <= 1'b0;
                        wrap           <= 1'b0;
                        wr_ptr_reg     <= '0;
                        rd_ptr_reg     <= '0;
                        fifo_count_reg <= '0;
                        busy           <= 1'b1;
                        if (hdr_mode) begin
                            state_reg <= HDR_LO;
                        end else begin
                            state_reg     <= DATA;
                            load_addr_reg <= FIXED_C;
                            addr_cnt_reg  <= FIXED_C;
                        end
                    end
                end

                HDR_LO: begin
                    if (!dl_active) begin
                        hdr_err   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (dl_wr) begin
                        load_lo_reg <= dl_data;
                        state_reg   <= HDR_HI;
                    end
                end

                HDR_HI: begin
                    if (!dl_active) begin
                        hdr_err   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (dl_wr) begin
                        load_addr_reg <= AW'({dl_data, load_lo_reg});
                        addr_cnt_reg  <= AW'({dl_data, load_lo_reg});
                        state_reg     <= DATA;
                    end
                end

                DATA: begin
                    // A strobe coinciding with the fall is pushed above.
                    if (!dl_active) begin
                        state_reg <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Done once the buffer is empty and the last write is
                    // either absent or being acknowledged this cycle.
                    if (fifo_empty && out_free) begin
                        if (inject_en_reg) begin
                            inj_idx_reg <= '0;
                            state_reg   <= INJECT;
                        end else if (autorun_hit) begin
                            force_reset  <= 1'b1;
                            hold_cnt_reg <= '0;
                            state_reg    <= RST;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end

                INJECT: begin
                    // All writes presented; leave on the final acknowledge.
                    if ((inj_idx_reg == INJ_LAST) && mem_req && mem_ack) begin
                        if (autorun_hit) begin
                            force_reset  <= 1'b1;
                            hold_cnt_reg <= '0;
                            state_reg    <= RST;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end

                RST: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        force_reset <= 1'b0;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// ----------------------------------------------------------------------------
// tb_prg_loader
//
// Directed testbench for prg_loader. A monitor logs every acknowledged memory
// write; each scenario builds a hand-computed list of expected writes and
// compares against the log, plus the status outputs.
// ----------------------------------------------------------------------------
module tb_prg_loader;

    logic        clk_sys;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic        hdr_mode;
    logic        inject_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        busy;
    logic [15:0] end_addr;
    logic        overrun;
    logic        hdr_err;
    logic        wrap;
    logic        force_reset;

    prg_loader dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_data     (dl_data),
        .hdr_mode    (hdr_mode),
        .inject_en   (inject_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .end_addr    (end_addr),
        .overrun     (overrun),
        .hdr_err     (hdr_err),
        .wrap        (wrap),
        .force_reset (force_reset)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ------------------------------------------------------------------------
    // Monitor: acknowledged writes, request cycles, reset-pulse cycles
    // ------------------------------------------------------------------------
    logic [15:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          req_cycles = 0;
    int          fr_cycles  = 0;

    always @(posedge clk_sys) begin
        if (reset_n && mem_req && mem_ack) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_dout);
            $display("write addr=%h data=%h", mem_addr, mem_dout);
        end
        if (reset_n && mem_req) req_cycles++;
        if (reset_n && force_reset) fr_cycles++;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [15:0] exp_a [$];
    logic [7:0]  exp_d [$];

    task automatic expect_w(input logic [15:0] a, input logic [7:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic check_writes(input string tag, input int base);
        int n;
        n = wr_a.size() - base;
        check({tag, "_count"}, n, exp_a.size());
        for (int i = 0; i < exp_a.size() && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_a[base+i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), wr_d[base+i], exp_d[i]);
        end
        exp_a.delete();
        exp_d.delete();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic hdr, input logic inj);
        hdr_mode  = hdr;
        inject_en = inj;
        dl_active = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        dl_wr   = 1'b1;
        dl_data = b;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    int base;
    int fr0;
    int req0;
    int n;

    initial begin
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = 8'h00;
        hdr_mode  = 1'b0;
        inject_en = 1'b0;
        mem_ack   = 1'b1;
        tick();
        tick();

        // ---- reset values ----
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_end_addr", end_addr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_hdr_err", hdr_err, 0);
        check("rst_wrap", wrap, 0);
        check("rst_force_reset", force_reset, 0);
        reset_n = 1'b1;
        tick();

        // ---- header load at 1201, ack tied high, injection on ----
        base = wr_a.size();
        fr0  = fr_cycles;
        start_dl(1'b1, 1'b1);
        check("hdr_busy", busy, 1);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_dl();
        wait_idle("hdr", 200);
        expect_w(16'h1201, 8'hAA);
        expect_w(16'h1202, 8'hBB);
        expect_w(16'h1203, 8'hCC);
        expect_w(16'h002D, 8'h04);
        expect_w(16'h002E, 8'h12);
        expect_w(16'h002F, 8'h04);
        expect_w(16'h0030, 8'h12);
        expect_w(16'h0031, 8'h04);
        expect_w(16'h0032, 8'h12);
        expect_w(16'h00AE, 8'h04);
        expect_w(16'h00AF, 8'h12);
        check_writes("hdr", base);
        check("hdr_end_addr", end_addr, 16'h1204);
        check("hdr_no_force_reset", fr_cycles - fr0, 0);
        check("hdr_overrun", overrun, 0);

        // ---- fixed mode at A000: injection then autostart reset ----
        base = wr_a.size();
        fr0  = fr_cycles;
        start_dl(1'b0, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        end_dl();
        wait_idle("fix", 300);
        expect_w(16'hA000, 8'h11);
        expect_w(16'hA001, 8'h22);
        expect_w(16'hA002, 8'h33);
        expect_w(16'h002D, 8'h03);
        expect_w(16'h002E, 8'hA0);
        expect_w(16'h002F, 8'h03);
        expect_w(16'h0030, 8'hA0);
        expect_w(16'h0031, 8'h03);
        expect_w(16'h0032, 8'hA0);
        expect_w(16'h00AE, 8'h03);
        expect_w(16'h00AF, 8'hA0);
        check_writes("fix", base);
        check("fix_end_addr", end_addr, 16'hA003);
        check("fix_force_reset_cycles", fr_cycles - fr0, 32);
        check("fix_force_reset_low", force_reset, 0);

        // ---- backpressure: ack low, six back-to-back bytes at 3000 ----
        base = wr_a.size();
        start_dl(1'b1, 1'b0);
        send_byte(8'h00);
        send_byte(8'h30);
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h51 + 8'(i));
        check("bp_overrun", overrun, 1);
        check("bp_req", mem_req, 1);
        check("bp_addr", mem_addr, 16'h3000);
        check("bp_dout", mem_dout, 8'h51);
        tick();
        tick();
        tick();
        check("bp_addr_stable", mem_addr, 16'h3000);
        check("bp_dout_stable", mem_dout, 8'h51);
        end_dl();
        mem_ack = 1'b1;
        wait_idle("bp", 200);
        n = wr_a.size() - base;
        check("bp_count_4_or_5", (n == 4 || n == 5), 1);
        for (int i = 0; i < n && i < 5; i++) begin
            check($sformatf("bp_addr%0d", i), wr_a[base+i], 16'h3000 + 16'(i));
            check($sformatf("bp_data%0d", i), wr_d[base+i], 8'h51 + 8'(i));
        end
        check("bp_overrun_sticky", overrun, 1);

        // ---- truncated header ----
        base = wr_a.size();
        req0 = req_cycles;
        start_dl(1'b1, 1'b1);
        check("trunc_overrun_cleared", overrun, 0);
        send_byte(8'h34);
        end_dl();
        wait_idle("trunc", 20);
        check("trunc_hdr_err", hdr_err, 1);
        check("trunc_no_req", req_cycles - req0, 0);
        check_writes("trunc", base);

        // ---- wrap: load at FFFE ----
        base = wr_a.size();
        fr0  = fr_cycles;
        start_dl(1'b1, 1'b0);
        check("wrap_hdr_err_cleared", hdr_err, 0);
        send_byte(8'hFE);
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        end_dl();
        wait_idle("wrap", 100);
        expect_w(16'hFFFE, 8'h01);
        expect_w(16'hFFFF, 8'h02);
        expect_w(16'h0000, 8'h03);
        check_writes("wrap", base);
        check("wrap_flag", wrap, 1);
        check("wrap_end_addr", end_addr, 16'h0001);
        check("wrap_no_force_reset", fr_cycles - fr0, 0);

        // ---- reset in the middle of a download ----
        mem_ack = 1'b0;
        start_dl(1'b0, 1'b0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        tick();
        check("mid_req_before", mem_req, 1);
        reset_n   = 1'b0;
        dl_active = 1'b0;
        #1;
        check("mid_mem_req", mem_req, 0);
        check("mid_mem_addr", mem_addr, 0);
        check("mid_mem_dout", mem_dout, 0);
        check("mid_busy", busy, 0);
        check("mid_end_addr", end_addr, 0);
        check("mid_wrap", wrap, 0);
        check("mid_force_reset", force_reset, 0);
        tick();
        reset_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        tick();
        check("post_rst_idle_req", mem_req, 0);

        base = wr_a.size();
        start_dl(1'b1, 1'b0);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h77);
        send_byte(8'h88);
        end_dl();
        wait_idle("post", 100);
        expect_w(16'h0400, 8'h77);
        expect_w(16'h0401, 8'h88);
        check_writes("post", base);
        check("post_end_addr", end_addr, 16'h0402);
        check("post_overrun", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
